// File: rtl/lsp_get_tdist_pkg.sv
// lsp_get_tdist_pkg: shared sizes, FSM encoding and saturation constants for the LSP distortion engine
package lsp_get_tdist_pkg;
  localparam int LSP_M = 10;
  localparam int LSP_AW = 11;
  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32 = 32'h8000_0000;
  localparam logic [15:0] MIN_16 = 16'h8000;
  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP, S_CALC1, S_CALC2, S_WRITE, S_DONE
  } state_e;
  // extract_h(L_shl(x, 4)): saturates when any of the top four bits would be lost
  function automatic logic [15:0] shl4_hi(input logic [31:0] x);
    logic [31:0] s;
    s = (x[31:27] == {5{x[31]}}) ? {x[27:0], 4'h0} : (x[31] ? MIN_32 : MAX_32);
    return s[31:16];
  endfunction
endpackage

// File: rtl/lsp_sat_mac.sv
// lsp_sat_mac: saturating c +/- L_mult(a, b) in Q-format
module lsp_sat_mac
  import lsp_get_tdist_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [31:0] c,
  input  logic        sub,
  output logic [31:0] sum
);
  logic signed [31:0] p;
  logic [31:0] prod;
  logic [32:0] s;
  always_comb begin
    p = $signed(a) * $signed(b);
    prod = (a == MIN_16 && b == MIN_16) ? MAX_32 : {p[30:0], 1'b0};
    s = sub ? {c[31], c} - {prod[31], prod} : {c[31], c} + {prod[31], prod};
    sum = (s[32] != s[31]) ? (s[32] ? MIN_32 : MAX_32) : s[31:0];
  end
endmodule

// File: rtl/lsp_get_tdist.sv
// lsp_get_tdist: accumulates the weighted squared LSP error over M coefficients and writes it to scratch memory
module lsp_get_tdist
  import lsp_get_tdist_pkg::*;
#(
  parameter int M = LSP_M,
  parameter int AW = LSP_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] wegtAddr,
  input  logic [AW-1:0] bufAddr,
  input  logic [AW-1:0] rbufAddr,
  input  logic [AW-1:0] fgSumAddr,
  input  logic [AW-1:0] tdistAddr,
  input  logic [31:0]   memIn,
  output logic [AW-1:0] memReadAddr,
  output logic [AW-1:0] memWriteAddr,
  output logic [31:0]   memOut,
  output logic          memWriteEn,
  output logic          done
);
  localparam int JW = $clog2(M);
  state_e state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic [AW-1:0] wegt_a_q, wegt_a_d, buf_a_q, buf_a_d, rbuf_a_q, rbuf_a_d;
  logic [AW-1:0] fg_a_q, fg_a_d, tdist_a_q, tdist_a_d, jx;
  logic [15:0] wegt_q, wegt_d, buf_q, buf_d, rbuf_q, rbuf_d, fg_q, fg_d, tmp_q, tmp_d;
  logic [31:0] tdist_q, tdist_d;
  logic [15:0] tmp2, mac_a, mac_b, unused_hi;
  logic [31:0] mac_c, acc_sum, w_sum;
  logic calc2;
  assign unused_hi = memIn[31:16];
  // One MAC is time-shared: L_acc in CALC1, the accumulate term in CALC2
  lsp_sat_mac u_acc (.a(mac_a), .b(mac_b), .c(mac_c), .sub(!calc2), .sum(acc_sum));
  lsp_sat_mac u_wgt (.a(wegt_q), .b(tmp_q), .c(32'h0), .sub(1'b0), .sum(w_sum));
  always_comb begin
    calc2 = state_q == S_CALC2;
    tmp2 = shl4_hi(w_sum);
    mac_a = calc2 ? tmp2 : rbuf_q;
    mac_b = calc2 ? tmp_q : fg_q;
    mac_c = calc2 ? tdist_q : {buf_q, 16'h0};
    jx = AW'(j_q);
    memReadAddr = state_q == S_RD0 ? wegt_a_q + jx :
                  state_q == S_RD1 ? buf_a_q + jx :
                  state_q == S_RD2 ? rbuf_a_q + jx :
                  state_q == S_RD3 ? fg_a_q + jx : '0;
    memWriteEn = state_q == S_WRITE;
    memWriteAddr = memWriteEn ? tdist_a_q : '0;
    memOut = memWriteEn ? tdist_q : '0;
    done = state_q == S_DONE;
  end
  always_comb begin
    state_d = state_q;
    j_d = j_q;
    wegt_a_d = wegt_a_q;
    buf_a_d = buf_a_q;
    rbuf_a_d = rbuf_a_q;
    fg_a_d = fg_a_q;
    tdist_a_d = tdist_a_q;
    wegt_d = wegt_q;
    buf_d = buf_q;
    rbuf_d = rbuf_q;
    fg_d = fg_q;
    tmp_d = tmp_q;
    tdist_d = tdist_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD0;
        j_d = '0;
        tdist_d = '0;
        wegt_a_d = wegtAddr;
        buf_a_d = bufAddr;
        rbuf_a_d = rbufAddr;
        fg_a_d = fgSumAddr;
        tdist_a_d = tdistAddr;
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin state_d = S_RD2; wegt_d = memIn[15:0]; end
      S_RD2: begin state_d = S_RD3; buf_d = memIn[15:0]; end
      S_RD3: begin state_d = S_CAP; rbuf_d = memIn[15:0]; end
      S_CAP: begin state_d = S_CALC1; fg_d = memIn[15:0]; end
      S_CALC1: begin state_d = S_CALC2; tmp_d = shl4_hi(acc_sum); end
      S_CALC2: begin
        tdist_d = acc_sum;
        j_d = j_q + 1'b1;
        state_d = (j_q == JW'(M - 1)) ? S_WRITE : S_RD0;
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      j_q <= '0;
      wegt_a_q <= '0;
      buf_a_q <= '0;
      rbuf_a_q <= '0;
      fg_a_q <= '0;
      tdist_a_q <= '0;
      wegt_q <= '0;
      buf_q <= '0;
      rbuf_q <= '0;
      fg_q <= '0;
      tmp_q <= '0;
      tdist_q <= '0;
    end else begin
      state_q <= state_d;
      j_q <= j_d;
      wegt_a_q <= wegt_a_d;
      buf_a_q <= buf_a_d;
      rbuf_a_q <= rbuf_a_d;
      fg_a_q <= fg_a_d;
      tdist_a_q <= tdist_a_d;
      wegt_q <= wegt_d;
      buf_q <= buf_d;
      rbuf_q <= rbuf_d;
      fg_q <= fg_d;
      tmp_q <= tmp_d;
      tdist_q <= tdist_d;
    end
  end
endmodule

// File: tb/tb_lsp_get_tdist.sv
// tb_lsp_get_tdist: directed and random runs of lsp_get_tdist against an integer-arithmetic distortion model
module tb_lsp_get_tdist;
  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [10:0] wegtAddr = 0, bufAddr = 0, rbufAddr = 0, fgSumAddr = 0, tdistAddr = 0;
  logic [31:0] memIn = 0;
  logic [10:0] memReadAddr, memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn, done;
  logic [31:0] mem [0:2047];
  logic [15:0] wv [10], bv [10], rv [10], fv [10];
  int          checks = 0, failures = 0;
  int          wr_count = 0, done_count = 0;
  logic [10:0] wr_addr = 0;
  logic [31:0] wr_data = 0;

  lsp_get_tdist dut (
    .clk(clk), .reset(reset), .start(start),
    .wegtAddr(wegtAddr), .bufAddr(bufAddr), .rbufAddr(rbufAddr),
    .fgSumAddr(fgSumAddr), .tdistAddr(tdistAddr), .memIn(memIn),
    .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memOut(memOut),
    .memWriteEn(memWriteEn), .done(done)
  );

  always #5 clk = ~clk;

  // scratch memory with one-cycle read latency; DUT writes are captured, not stored
  always @(posedge clk) begin
    memIn <= mem[memReadAddr];
    if (memWriteEn) begin
      wr_count <= wr_count + 1;
      wr_addr <= memWriteAddr;
      wr_data <= memOut;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction
  function automatic longint sat32(input longint x);
    longint mx = 2147483647;
    return x > mx ? mx : (x < -mx - 1 ? -mx - 1 : x);
  endfunction
  function automatic longint lmult(input longint a, input longint b);
    return (a == -32768 && b == -32768) ? 64'sd2147483647 : 2 * a * b;
  endfunction
  function automatic longint hi4(input longint x);
    return sat32(x * 16) >>> 16;
  endfunction
  function automatic logic [31:0] ref_tdist();
    longint acc = 0, lacc, t, t2;
    for (int j = 0; j < 10; j++) begin
      lacc = sat32(sx(bv[j]) * 65536 - lmult(sx(rv[j]), sx(fv[j])));
      t = hi4(lacc);
      t2 = hi4(lmult(sx(wv[j]), t));
      acc = sat32(acc + lmult(t2, t));
    end
    return acc[31:0];
  endfunction

  task automatic fill(input logic [15:0] w, input logic [15:0] b, input logic [15:0] r, input logic [15:0] f);
    for (int j = 0; j < 10; j++) begin
      wv[j] = w; bv[j] = b; rv[j] = r; fv[j] = f;
    end
  endtask

  task automatic run_case(input string tag, input logic [10:0] bw, input logic [10:0] bb,
                          input logic [10:0] br, input logic [10:0] bf, input logic [10:0] bt,
                          input int restart_at, input int abort_at);
    logic [31:0] exp;
    logic [10:0] ra;
    int wc, dc;
    for (int j = 0; j < 10; j++) begin
      mem[11'(bw + j)] = {16'($urandom), wv[j]};
      mem[11'(bb + j)] = {16'($urandom), bv[j]};
      mem[11'(br + j)] = {16'($urandom), rv[j]};
      mem[11'(bf + j)] = {16'($urandom), fv[j]};
    end
    exp = ref_tdist();
    wegtAddr = bw; bufAddr = bb; rbufAddr = br; fgSumAddr = bf; tdistAddr = bt;
    wc = wr_count;
    dc = done_count;
    @(negedge clk);
    start = 1;
    for (int k = 0; k < 73; k++) begin
      @(posedge clk);
      #1;
      start = (k == restart_at);
      wegtAddr = 11'($urandom);
      tdistAddr = 11'($urandom);
      if (k == abort_at) begin
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        chk({tag, "_rst_rdaddr"}, 32'(memReadAddr), 0);
        chk({tag, "_rst_we"}, 32'(memWriteEn), 0);
        repeat (80) @(posedge clk);
        #1;
        chk({tag, "_no_write"}, 32'(wr_count), 32'(wc));
        chk({tag, "_no_done"}, 32'(done_count), 32'(dc));
        return;
      end
      if (k < 70 && k % 7 < 4) begin
        ra = (k % 7 == 0 ? bw : k % 7 == 1 ? bb : k % 7 == 2 ? br : bf) + 11'(k / 7);
        chk($sformatf("%s_rd%0d", tag, k), 32'(memReadAddr), 32'(ra));
      end
      if (k == 69) chk({tag, "_we_early"}, 32'(memWriteEn), 0);
      if (k == 70) begin
        chk({tag, "_we"}, 32'(memWriteEn), 1);
        chk({tag, "_waddr"}, 32'(memWriteAddr), 32'(bt));
        chk({tag, "_tdist"}, memOut, exp);
        chk({tag, "_done_early"}, 32'(done), 0);
      end
      if (k == 71) begin
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_we_off"}, 32'(memWriteEn), 0);
        chk({tag, "_mout_off"}, memOut, 0);
        chk({tag, "_waddr_off"}, 32'(memWriteAddr), 0);
      end
      if (k == 72) chk({tag, "_done_off"}, 32'(done), 0);
    end
    chk({tag, "_wcount"}, 32'(wr_count), 32'(wc + 1));
    chk({tag, "_wdata"}, wr_data, exp);
    chk({tag, "_waddr_mem"}, 32'(wr_addr), 32'(bt));
  endtask

  initial begin
    logic [10:0] r;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 32'(done), 0);
    chk("reset_we", 32'(memWriteEn), 0);
    chk("reset_rdaddr", 32'(memReadAddr), 0);
    chk("reset_waddr", 32'(memWriteAddr), 0);
    chk("reset_mout", memOut, 0);
    reset = 1;
    @(negedge clk);

    fill(16'h0, 16'h0, 16'h0, 16'h0);
    run_case("zero", 11'h100, 11'h120, 11'h140, 11'h160, 11'h200, -1, -1);

    fill(16'h2000, 16'h0100, 16'h0, 16'h0);
    run_case("plain", 11'h010, 11'h030, 11'h050, 11'h070, 11'h0F0, -1, -1);
    chk("plain_const", wr_data, 32'h5000_0000);

    fill(16'h7FFF, 16'h7FFF, 16'h0, 16'h0);
    run_case("acc_sat", 11'h300, 11'h320, 11'h340, 11'h360, 11'h3A0, -1, -1);
    chk("acc_sat_const", wr_data, 32'h7FFF_FFFF);

    fill(16'h0, 16'h0, 16'h0, 16'h0);
    wv[0] = 16'h2000; rv[0] = 16'h7FFF; fv[0] = 16'h7FFF;
    run_case("mult_sat", 11'h400, 11'h420, 11'h440, 11'h460, 11'h4A0, -1, -1);
    chk("mult_sat_const", wr_data, 32'h7FFF_FFFF);

    for (int j = 0; j < 10; j++) begin
      wv[j] = 16'($urandom_range(0, 16'h3FFF));
      bv[j] = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
      rv[j] = 16'($urandom);
      fv[j] = 16'($urandom_range(0, 16'h00FF));
    end
    run_case("wrap", 11'h7FC, 11'h7F0, 11'h7E4, 11'h7D8, 11'h7FA, -1, -1);

    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < 10; j++) begin
        wv[j] = (n == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF));
        bv[j] = (n == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
        rv[j] = 16'($urandom);
        fv[j] = (n == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h01FF));
      end
      r = 11'($urandom);
      run_case($sformatf("rand%0d", n), r, r + 11'd16, r + 11'd32, r + 11'd48, r + 11'd64, -1, -1);
    end

    fill(16'h2000, 16'h0100, 16'h0, 16'h0);
    run_case("abort", 11'h500, 11'h520, 11'h540, 11'h560, 11'h5A0, 10, 29);
    for (int j = 0; j < 10; j++) begin
      wv[j] = 16'($urandom_range(0, 16'h3FFF));
      bv[j] = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
      rv[j] = 16'($urandom);
      fv[j] = 16'($urandom_range(0, 16'h01FF));
    end
    run_case("after_abort", 11'h600, 11'h620, 11'h640, 11'h660, 11'h6A0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
